// File: rtl/ex_stage_if.sv
// ex_stage_if: ID/EX inputs and EX/MEM outputs of the execute stage.
interface ex_stage_if #(parameter int DATA_W = 8, parameter int REG_IDX_W = 2);
   logic                 flush, wr_en, reg_write, mem_read, mem_write, flag_en, wb_reg_write;
   logic [REG_IDX_W-1:0] dst_reg, ra_idx, rb_idx, wb_dst;
   logic [3:0]           alu_sel;
   logic [1:0]           op2_sel, wb_sel;
   logic [DATA_W-1:0]    ra_val, rb_val, imm, pc, wb_data;
   logic [3:0]           ccr_out;
   logic                 ex_reg_write, ex_mem_read, ex_mem_write;
   logic [REG_IDX_W-1:0] ex_dst_reg;
   logic [1:0]           ex_wb_sel;
   logic [DATA_W-1:0]    ex_alu_result, ex_store_data, ex_pc;
   modport master (
      output flush, wr_en, reg_write, dst_reg, alu_sel, op2_sel, wb_sel, mem_read, mem_write,
             flag_en, ra_idx, rb_idx, ra_val, rb_val, imm, pc, wb_reg_write, wb_dst, wb_data,
      input  ccr_out, ex_reg_write, ex_dst_reg, ex_wb_sel, ex_mem_read, ex_mem_write,
             ex_alu_result, ex_store_data, ex_pc
   );
   modport slave (
      input  flush, wr_en, reg_write, dst_reg, alu_sel, op2_sel, wb_sel, mem_read, mem_write,
             flag_en, ra_idx, rb_idx, ra_val, rb_val, imm, pc, wb_reg_write, wb_dst, wb_data,
      output ccr_out, ex_reg_write, ex_dst_reg, ex_wb_sel, ex_mem_read, ex_mem_write,
             ex_alu_result, ex_store_data, ex_pc
   );
endinterface

// File: rtl/ex_stage.sv
// ex_stage: forwarding, op2 select, ALU, CCR and EX/MEM register.
// Define EX_FWD_EN to enable EX/MEM and WB operand forwarding.
module ex_stage #(
   parameter int DATA_W    = 8,
   parameter int REG_IDX_W = 2
) (
   input logic       clk,
   input logic       rst,
   ex_stage_if.slave ex
);
   logic [DATA_W-1:0]    w_a, w_fb, w_b, w_opd, w_res;
   logic [DATA_W:0]      w_sum, w_dif;
   logic                 w_c, w_v, w_zn;
   logic [3:0]           w_ccr_nxt;
   logic [3:0]           r_ccr;
   logic                 r_reg_write, r_mem_read, r_mem_write;
   logic [REG_IDX_W-1:0] r_dst;
   logic [1:0]           r_wb_sel;
   logic [DATA_W-1:0]    r_res, r_sd, r_pc;
`ifdef EX_FWD_EN
   // Loads in EX/MEM are excluded: their data does not exist yet.
   assign w_a  = (r_reg_write && r_wb_sel == 2'd0 && r_dst == ex.ra_idx) ? r_res :
                 (ex.wb_reg_write && ex.wb_dst == ex.ra_idx) ? ex.wb_data : ex.ra_val;
   assign w_fb = (r_reg_write && r_wb_sel == 2'd0 && r_dst == ex.rb_idx) ? r_res :
                 (ex.wb_reg_write && ex.wb_dst == ex.rb_idx) ? ex.wb_data : ex.rb_val;
`else
   assign w_a  = ex.ra_val;
   assign w_fb = ex.rb_val;
`endif
   assign w_b   = ex.op2_sel == 2'd0 ? w_fb : ex.op2_sel == 2'd1 ? ex.imm :
                  ex.op2_sel == 2'd2 ? ex.pc : '0;
   assign w_opd = (ex.alu_sel == 4'd7 || ex.alu_sel == 4'd8) ? DATA_W'(1) : w_b;
   assign w_sum = {1'b0, w_a} + {1'b0, w_opd};
   assign w_dif = {1'b0, w_a} - {1'b0, w_opd};
   always_comb begin
      w_res = w_a;
      w_c   = r_ccr[2];
      w_v   = r_ccr[3];
      w_zn  = 1'b1;
      case (ex.alu_sel)
         4'd1, 4'd7: begin
            w_res = w_sum[DATA_W-1:0];
            w_c   = w_sum[DATA_W];
            w_v   = (w_a[DATA_W-1] == w_opd[DATA_W-1]) && (w_sum[DATA_W-1] != w_a[DATA_W-1]);
         end
         4'd2, 4'd8: begin
            w_res = w_dif[DATA_W-1:0];
            w_c   = w_dif[DATA_W];
            w_v   = (w_a[DATA_W-1] != w_opd[DATA_W-1]) && (w_dif[DATA_W-1] != w_a[DATA_W-1]);
         end
         4'd3:  w_res = w_a & w_b;
         4'd4:  w_res = w_a | w_b;
         4'd5:  w_res = w_a ^ w_b;
         4'd6:  w_res = ~w_a;
         4'd9:  begin w_res = {w_a[DATA_W-2:0], 1'b0};     w_c = w_a[DATA_W-1]; end
         4'd10: begin w_res = {1'b0, w_a[DATA_W-1:1]};     w_c = w_a[0];        end
         4'd11: begin w_res = {w_a[DATA_W-2:0], r_ccr[2]}; w_c = w_a[DATA_W-1]; end
         4'd12: begin w_res = {r_ccr[2], w_a[DATA_W-1:1]}; w_c = w_a[0];        end
         4'd13: w_res = w_b;
         4'd14: begin w_c = 1'b1; w_zn = 1'b0; end
         4'd15: begin w_c = 1'b0; w_zn = 1'b0; end
         default: w_res = w_a;
      endcase
   end
   assign w_ccr_nxt = {w_v, w_c, w_zn ? w_res[DATA_W-1] : r_ccr[1], w_zn ? (w_res == '0) : r_ccr[0]};
   always_ff @(posedge clk) begin
      if (rst) begin
         r_ccr       <= '0;
         r_reg_write <= 1'b0;
         r_dst       <= '0;
         r_wb_sel    <= '0;
         r_mem_read  <= 1'b0;
         r_mem_write <= 1'b0;
         r_res       <= '0;
         r_sd        <= '0;
         r_pc        <= '0;
      end else if (ex.flush) begin
         r_reg_write <= 1'b0;
         r_dst       <= '0;
         r_wb_sel    <= '0;
         r_mem_read  <= 1'b0;
         r_mem_write <= 1'b0;
         r_res       <= '0;
         r_sd        <= '0;
         r_pc        <= '0;
      end else if (ex.wr_en) begin
         r_reg_write <= ex.reg_write;
         r_dst       <= ex.dst_reg;
         r_wb_sel    <= ex.wb_sel;
         r_mem_read  <= ex.mem_read;
         r_mem_write <= ex.mem_write;
         r_res       <= w_res;
         r_sd        <= w_fb;
         r_pc        <= ex.pc;
         if (ex.flag_en) r_ccr <= w_ccr_nxt;
      end
   end
   assign ex.ccr_out       = r_ccr;
   assign ex.ex_reg_write  = r_reg_write;
   assign ex.ex_dst_reg    = r_dst;
   assign ex.ex_wb_sel     = r_wb_sel;
   assign ex.ex_mem_read   = r_mem_read;
   assign ex.ex_mem_write  = r_mem_write;
   assign ex.ex_alu_result = r_res;
   assign ex.ex_store_data = r_sd;
   assign ex.ex_pc         = r_pc;
endmodule

// File: tb/tb_ex_stage.sv
// tb_ex_stage: directed and random checks of ex_stage against an integer reference model.
module tb_ex_stage;
   logic clk = 1'b0;
   logic rst;
   int   total = 0;
   int   bad = 0;
   bit [3:0] m_ccr;
   int   m_rw, m_dst, m_wbs, m_mr, m_mw, m_res, m_sd, m_pc;
   ex_stage_if bus ();
   ex_stage dut (.clk(clk), .rst(rst), .ex(bus));
   always #5 clk = ~clk;
   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
      end
   endtask
   task automatic rnd();
      bus.flush        = 1'($urandom);
      bus.wr_en        = 1'($urandom);
      bus.reg_write    = 1'($urandom);
      bus.dst_reg      = 2'($urandom);
      bus.alu_sel      = 4'($urandom);
      bus.op2_sel      = 2'($urandom);
      bus.wb_sel       = 2'($urandom);
      bus.mem_read     = 1'($urandom);
      bus.mem_write    = 1'($urandom);
      bus.flag_en      = 1'($urandom);
      bus.ra_idx       = 2'($urandom);
      bus.rb_idx       = 2'($urandom);
      bus.ra_val       = 8'($urandom);
      bus.rb_val       = 8'($urandom);
      bus.imm          = 8'($urandom);
      bus.pc           = 8'($urandom);
      bus.wb_reg_write = 1'($urandom);
      bus.wb_dst       = 2'($urandom);
      bus.wb_data      = 8'($urandom);
   endtask
   task automatic quiet();
      rnd();
      rst = 1'b0;
      bus.flush = 1'b0;
      bus.wr_en = 1'b1;
      bus.reg_write = 1'b0;
      bus.wb_reg_write = 1'b0;
   endtask
   function automatic int sgn(input int x);
      return x > 127 ? x - 256 : x;
   endfunction
   // One clock: predict from the current model state, advance, compare every output.
   task automatic cycle();
      int a, fb, b, r, s;
      bit c, v, zn;
      a  = int'(bus.ra_val);
      fb = int'(bus.rb_val);
`ifdef EX_FWD_EN
      if (m_rw == 1 && m_wbs == 0 && m_dst == int'(bus.ra_idx)) a = m_res;
      else if (bus.wb_reg_write && bus.wb_dst == bus.ra_idx) a = int'(bus.wb_data);
      if (m_rw == 1 && m_wbs == 0 && m_dst == int'(bus.rb_idx)) fb = m_res;
      else if (bus.wb_reg_write && bus.wb_dst == bus.rb_idx) fb = int'(bus.wb_data);
`endif
      b = bus.op2_sel == 0 ? fb : bus.op2_sel == 1 ? int'(bus.imm) : bus.op2_sel == 2 ? int'(bus.pc) : 0;
      c = m_ccr[2];
      v = m_ccr[3];
      zn = 1'b1;
      r = a;
      case (int'(bus.alu_sel))
         1:  begin r = a + b; c = r > 255; s = sgn(a) + sgn(b); v = s > 127 || s < -128; end
         2:  begin r = a - b; c = a < b;   s = sgn(a) - sgn(b); v = s > 127 || s < -128; end
         3:  r = a & b;
         4:  r = a | b;
         5:  r = a ^ b;
         6:  r = 255 - a;
         7:  begin r = a + 1; c = a == 255; v = a == 127; end
         8:  begin r = a - 1; c = a == 0;   v = a == 128; end
         9:  begin r = a * 2; c = a >= 128; end
         10: begin r = a / 2; c = (a % 2) == 1; end
         11: begin r = a * 2 + int'(m_ccr[2]); c = a >= 128; end
         12: begin r = a / 2 + 128 * int'(m_ccr[2]); c = (a % 2) == 1; end
         13: r = b;
         14: begin c = 1'b1; zn = 1'b0; end
         15: begin c = 1'b0; zn = 1'b0; end
         default: r = a;
      endcase
      r = r & 255;
      @(posedge clk);
      if (rst) begin
         m_ccr = 4'd0;
         {m_rw, m_dst, m_wbs, m_mr, m_mw, m_res, m_sd, m_pc} = '0;
      end else if (bus.flush) begin
         {m_rw, m_dst, m_wbs, m_mr, m_mw, m_res, m_sd, m_pc} = '0;
      end else if (bus.wr_en) begin
         m_rw  = int'(bus.reg_write);
         m_dst = int'(bus.dst_reg);
         m_wbs = int'(bus.wb_sel);
         m_mr  = int'(bus.mem_read);
         m_mw  = int'(bus.mem_write);
         m_res = r;
         m_sd  = fb;
         m_pc  = int'(bus.pc);
         if (bus.flag_en) m_ccr = {v, c, zn ? r >= 128 : m_ccr[1], zn ? r == 0 : m_ccr[0]};
      end
      #1;
      chk("ccr", 32'(bus.ccr_out), 32'(m_ccr));
      chk("ctl", 32'({bus.ex_reg_write, bus.ex_dst_reg, bus.ex_wb_sel, bus.ex_mem_read, bus.ex_mem_write}),
          32'(m_rw * 64 + m_dst * 16 + m_wbs * 4 + m_mr * 2 + m_mw));
      chk("res", 32'(bus.ex_alu_result), m_res);
      chk("store", 32'(bus.ex_store_data), m_sd);
      chk("pc", 32'(bus.ex_pc), m_pc);
      @(negedge clk);
   endtask
   initial begin
      m_ccr = 4'd0;
      {m_rw, m_dst, m_wbs, m_mr, m_mw, m_res, m_sd, m_pc} = '0;
      for (int i = 0; i < 2; i++) begin
         rnd();
         rst = 1'b1;
         cycle();
      end
      chk("rst_ccr", 32'(bus.ccr_out), 32'd0);
      chk("rst_res", 32'(bus.ex_alu_result), 32'd0);
      chk("rst_ctl", 32'({bus.ex_reg_write, bus.ex_mem_read, bus.ex_mem_write, bus.ex_wb_sel}), 32'd0);
      quiet(); bus.ra_val = 8'h7F; bus.imm = 8'h01; bus.op2_sel = 2'd1; bus.alu_sel = 4'd1; bus.flag_en = 1'b1;
      cycle();
      chk("add_res", 32'(bus.ex_alu_result), 32'h80);
      chk("add_ccr", 32'(bus.ccr_out), 32'b1010);
      quiet(); bus.ra_val = 8'h05; bus.rb_val = 8'h05; bus.op2_sel = 2'd0; bus.alu_sel = 4'd2; bus.flag_en = 1'b1;
      cycle();
      chk("sub_res", 32'(bus.ex_alu_result), 32'h00);
      chk("sub_ccr", 32'(bus.ccr_out), 32'b0001);
      quiet(); bus.ra_val = 8'h01; bus.rb_val = 8'h02; bus.op2_sel = 2'd0; bus.alu_sel = 4'd2; bus.flag_en = 1'b1;
      bus.wr_en = 1'b0;
      cycle();
      chk("stall_res", 32'(bus.ex_alu_result), 32'h00);
      chk("stall_ccr", 32'(bus.ccr_out), 32'b0001);
      quiet(); bus.alu_sel = 4'd13; bus.op2_sel = 2'd1; bus.imm = 8'h10; bus.reg_write = 1'b1;
      bus.dst_reg = 2'd1; bus.wb_sel = 2'd0; bus.flag_en = 1'b0;
      cycle();
      quiet(); bus.ra_idx = 2'd1; bus.ra_val = 8'h55; bus.wb_reg_write = 1'b1; bus.wb_dst = 2'd1;
      bus.wb_data = 8'h20; bus.alu_sel = 4'd1; bus.op2_sel = 2'd3; bus.flag_en = 1'b0;
      cycle();
`ifdef EX_FWD_EN
      chk("fwd_exmem", 32'(bus.ex_alu_result), 32'h10);
`else
      chk("fwd_exmem", 32'(bus.ex_alu_result), 32'h55);
`endif
      quiet(); bus.ra_idx = 2'd1; bus.ra_val = 8'h55; bus.wb_reg_write = 1'b1; bus.wb_dst = 2'd1;
      bus.wb_data = 8'h20; bus.alu_sel = 4'd1; bus.op2_sel = 2'd3; bus.flag_en = 1'b0;
      cycle();
`ifdef EX_FWD_EN
      chk("fwd_wb", 32'(bus.ex_alu_result), 32'h20);
`else
      chk("fwd_wb", 32'(bus.ex_alu_result), 32'h55);
`endif
      quiet(); bus.reg_write = 1'b1; bus.mem_read = 1'b1; bus.mem_write = 1'b1; bus.wb_sel = 2'd2;
      bus.alu_sel = 4'd1; bus.flag_en = 1'b1; bus.flush = 1'b1; bus.wr_en = 1'b1;
      cycle();
      chk("flush_ctl", 32'({bus.ex_reg_write, bus.ex_mem_read, bus.ex_mem_write, bus.ex_wb_sel}), 32'd0);
      chk("flush_ccr", 32'(bus.ccr_out), 32'b0001);
      quiet(); bus.alu_sel = 4'd14; bus.flag_en = 1'b1;
      cycle();
      chk("setc_ccr", 32'(bus.ccr_out), 32'b0101);
      quiet(); bus.alu_sel = 4'd11; bus.ra_val = 8'h80; bus.flag_en = 1'b1;
      cycle();
      chk("rol_res", 32'(bus.ex_alu_result), 32'h01);
      chk("rol_c", 32'(bus.ccr_out[2]), 32'd1);
      quiet(); bus.alu_sel = 4'd5; bus.flag_en = 1'b1;
      cycle();
      chk("xor_c", 32'(bus.ccr_out[2]), 32'd1);
      for (int i = 0; i < 500; i++) begin
         rnd();
         rst = $urandom_range(0, 39) == 0;
         bus.flush = $urandom_range(0, 7) == 0;
         bus.wr_en = $urandom_range(0, 3) != 0;
         cycle();
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/ex_stage.md
Name: ex_stage

Overview:
- Execute stage of the 8-bit 4-register pipeline. Consumes the ID/EX register outputs and performs operand forwarding, op2 selection and the ALU operation.
- Owns the condition-code register (CCR: Z,N,C,V).
- Registers the EX/MEM pipeline boundary, with stall and flush, toward the MEM stage.

Parameters:
- DATA_W, 8, datapath width; CCR arithmetic is defined for 8.
- REG_IDX_W, 2, register index width.

Ports:
- clk  in  1  clock, all state on rising edge
- rst  in  1  synchronous active-high reset
- flush  in  1  squash EX/MEM contents on this edge
- wr_en  in  1  advance EX/MEM register; 0 = stall/hold
- reg_write  in  1  from ID/EX
- dst_reg  in  2  from ID/EX
- alu_sel  in  4  from ID/EX
- op2_sel  in  2  from ID/EX
- wb_sel  in  2  from ID/EX (0 ALU, 1 MEM, 2 PC)
- mem_read  in  1  from ID/EX
- mem_write  in  1  from ID/EX
- flag_en  in  1  from ID/EX
- ra_idx  in  2  source index of operand A
- rb_idx  in  2  source index of operand B
- ra_val  in  8  from ID/EX
- rb_val  in  8  from ID/EX
- imm  in  8  from ID/EX
- pc  in  8  from ID/EX
- wb_reg_write  in  1  WB-stage write enable
- wb_dst  in  2  WB-stage destination
- wb_data  in  8  WB-stage write data
- ccr_out  out  4  {V,C,N,Z}, registered
- ex_reg_write  out  1  EX/MEM control
- ex_dst_reg  out  2  EX/MEM control
- ex_wb_sel  out  2  EX/MEM control
- ex_mem_read  out  1  EX/MEM control
- ex_mem_write  out  1  EX/MEM control
- ex_alu_result  out  8  registered ALU result
- ex_store_data  out  8  registered forwarded B value (store data)
- ex_pc  out  8  registered PC

Behaviour:
- Reset: on a rising clk edge with rst=1, all outputs and ccr_out are cleared to 0. rst overrides flush and wr_en, including mid-stall.
- Forwarding, operand A:
  - First choice: EX/MEM, if ex_reg_write=1, ex_wb_sel=0 and ex_dst_reg==ra_idx; value is ex_alu_result.
  - Otherwise: WB, if wb_reg_write=1 and wb_dst==ra_idx; value is wb_data.
  - Otherwise: ra_val.
- Forwarding, operand B: same rules using rb_idx and rb_val; the result is fwd_b.
- op2 selection:
  - 0: fwd_b
  - 1: imm
  - 2: pc
  - 3: 8'h00
- ALU ops (alu_sel; A = forwarded A, B = op2; all 8-bit, wrap-around):
  - 0: pass A
  - 1: A+B
  - 2: A-B
  - 3: AND
  - 4: OR
  - 5: XOR
  - 6: ~A
  - 7: A+1
  - 8: A-1
  - 9: shl A
  - 10: shr A
  - 11: rotate left through C
  - 12: rotate right through C
  - 13: pass B
  - 14: SETC
  - 15: CLRC
- Flags:
  - Z = (result==0); N = result[7].
  - C = carry-out for add/inc; C = borrow for sub/dec; C = shifted-out bit for ops 9-12.
  - V = signed overflow for add/sub/inc/dec.
  - Logic ops leave C and V unchanged. Ops 14/15 change only C.
- CCR update: only when flag_en=1, wr_en=1 and flush=0. A stalled or flushed instruction never alters the CCR.
- EX/MEM register update, in priority order:
  - rst.
  - flush: all control outputs 0, data outputs 0.
  - wr_en=1: capture new values.
  - Otherwise: hold all values.
- Latency: result available at EX/MEM one cycle after ID/EX presents it.
- Simultaneous flush=1 and wr_en=1: flush wins.
- An EX/MEM entry holding a MEM load (ex_wb_sel=1) is never a forward source. Load-use stalls are resolved upstream.

Optional Feature:
- Macro EX_FWD_EN.
- Defined: forwarding as above.
- Undefined: operand A = ra_val and fwd_b = rb_val unconditionally. ra_idx, rb_idx, wb_reg_write, wb_dst and wb_data are unused. Software or upstream stalls handle hazards.

Test Plan:
- rst=1 for 2 cycles with random inputs -> all outputs and ccr_out 0.
- ADD ra_val=8'h7F, imm=8'h01, op2_sel=1, flag_en=1, wr_en=1 -> ex_alu_result=8'h80, ccr_out V=1 N=1 C=0 Z=0 next cycle.
- SUB 8'h05-8'h05 -> result 0, Z=1; then wr_en=0 with SUB 1-2 presented -> outputs and CCR unchanged.
- Back-to-back writes to R1 (EX/MEM 8'h10, WB 8'h20) with next ra_idx=1, A+0 -> result 8'h10 (EX/MEM priority). With EX_FWD_EN undefined -> result = ra_val.
- flush=1 and wr_en=1 on a flag-setting ADD -> EX/MEM control outputs 0, CCR unchanged.
- SETC, then rotate left 8'h80 (op 11) -> result 8'h01, C=1. Then XOR -> C still 1.
